// File: rtl/subtractor_32bit.sv
// 32-bit ripple-carry subtractor (a + ~b + 1) with registered difference, carry and overflow flags.
// Optional registered zero flag when SUB_ZERO_FLAG_EN is defined.

module subtractor_32bit_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ c;
  assign co = (a & b) ^ (c & p);
endmodule

module subtractor_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
`ifdef SUB_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             out_valid
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             cout;
    logic             ovf;
    logic             zf;
  } res_t;

  logic [WIDTH-1:0] bmod;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   carry;
  logic [STAGES-1:0] vld_pipe;
  res_t res_c, res_q;

  // Subtraction as addition: invert b and inject the +1 through carry[0].
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bmod[i] = ~b[i];
    subtractor_32bit_fa u_fa (
      .a  (a[i]),
      .b  (bmod[i]),
      .c  (carry[i]),
      .s  (diff[i]),
      .co (carry[i+1])
    );
  end

  always_comb begin
    res_c      = '0;
    res_c.diff = diff;
    res_c.cout = carry[WIDTH];
    res_c.ovf  = (a[WIDTH-1] == bmod[WIDTH-1]) && (diff[WIDTH-1] != bmod[WIDTH-1]);
    res_c.zf   = ~|diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= STAGES'(in_valid);
      if (in_valid) res_q <= res_c;
    end
  end

  assign sum       = res_q.diff;
  assign carryout  = res_q.cout;
  assign overflow  = res_q.ovf;
  assign out_valid = vld_pipe[STAGES-1];
`ifdef SUB_ZERO_FLAG_EN
  assign zero      = res_q.zf;
`else
  logic unused_zf;
  assign unused_zf = res_q.zf;
`endif

endmodule

// File: tb/tb_subtractor_32bit.sv
// Directed and random checks for subtractor_32bit; zero flag checked when SUB_ZERO_FLAG_EN is defined.

module tb_subtractor_32bit;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a, b;
  logic [31:0] sum;
  logic        carryout, overflow, out_valid;
`ifdef SUB_ZERO_FLAG_EN
  logic        zero;
`endif

  int checks   = 0;
  int failures = 0;

  subtractor_32bit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .carryout  (carryout),
    .overflow  (overflow),
`ifdef SUB_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand pair at the falling edge, then look just after the capturing edge.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic v);
    @(negedge clk);
    a = ta; b = tb_; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 32'h5; b = 32'h3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sum, carryout, overflow, out_valid} !== 35'h0) begin
      failures++;
      $display("FAIL reset_hold got sum=%h c=%b v=%b ov=%b want all 0", sum, carryout, overflow, out_valid);
    end
`ifdef SUB_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin failures++; $display("FAIL reset_zero got %b want 0", zero); end
`endif
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_signed_min();
    issue(32'h8000_0000, 32'h0000_0001, 1'b1);
    checks++;
    if ({sum, carryout, overflow, out_valid} !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL signed_min got sum=%h c=%b ov=%b vld=%b want 7fffffff 1 1 1", sum, carryout, overflow, out_valid);
    end
  endtask

  task automatic test_borrow();
    issue(32'h0000_0000, 32'h0000_0001, 1'b1);
    checks++;
    if ({sum, carryout, overflow, out_valid} !== {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL borrow got sum=%h c=%b ov=%b vld=%b want ffffffff 0 0 1", sum, carryout, overflow, out_valid);
    end
`ifdef SUB_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin failures++; $display("FAIL borrow_zero got %b want 0", zero); end
`endif
    issue(32'h0000_0000, 32'h0000_0000, 1'b1);
    checks++;
    if ({sum, carryout, overflow} !== {32'h0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL zero_minus_zero got sum=%h c=%b ov=%b want 0 1 0", sum, carryout, overflow);
    end
  endtask

  task automatic test_equal_overflow();
    issue(32'h1234_5678, 32'h1234_5678, 1'b1);
    checks++;
    if ({sum, carryout, overflow, out_valid} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL equal got sum=%h c=%b ov=%b vld=%b want 0 1 0 1", sum, carryout, overflow, out_valid);
    end
`ifdef SUB_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b1) begin failures++; $display("FAIL equal_zero got %b want 1", zero); end
`endif
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    checks++;
    if ({sum, carryout, overflow, out_valid} !== {32'h8000_0000, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL pos_overflow got sum=%h c=%b ov=%b vld=%b want 80000000 0 1 1", sum, carryout, overflow, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [3] = '{32'h5, 32'h3, 32'h8000_0000};
    logic [31:0] vb [3] = '{32'h3, 32'h5, 32'h8000_0000};
    logic [33:0] ve [3] = '{{32'h2, 2'b10}, {32'hFFFF_FFFE, 2'b00}, {32'h0, 2'b10}};
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], 1'b1);
      checks++;
      if ({sum, carryout, overflow, out_valid} !== {ve[i], 1'b1}) begin
        failures++;
        $display("FAIL b2b_%0d got sum=%h c=%b ov=%b vld=%b want %h %b %b 1", i, sum, carryout, overflow,
                 out_valid, ve[i][33:2], ve[i][1], ve[i][0]);
      end
    end
  endtask

  task automatic test_hold();
    issue(32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
    checks++;
    if ({sum, carryout, overflow, out_valid} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL hold got sum=%h c=%b ov=%b vld=%b want 0 1 0 0", sum, carryout, overflow, out_valid);
    end
`ifdef SUB_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b1) begin failures++; $display("FAIL hold_zero got %b want 1", zero); end
`endif
  endtask

  task automatic test_async_reset();
    issue(32'h0000_0010, 32'h0000_0001, 1'b1);
    checks++;
    if ({sum, carryout, out_valid} !== {32'hF, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL pre_async got sum=%h c=%b vld=%b want f 1 1", sum, carryout, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sum, carryout, overflow, out_valid} !== 35'h0) begin
      failures++;
      $display("FAIL async_reset got sum=%h c=%b ov=%b vld=%b want all 0", sum, carryout, overflow, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, es;
    logic        ec, ev;
    longint      sd;
    int          bad = 0;
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 7 == 0) rb = ra;
      issue(ra, rb, 1'b1);
      es = ra - rb;
      ec = (ra >= rb);
      sd = longint'($signed(ra)) - longint'($signed(rb));
      ev = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      checks++;
      if ({sum, carryout, overflow, out_valid} !== {es, ec, ev, 1'b1}) begin
        failures++;
        if (bad++ < 5)
          $display("FAIL random a=%h b=%h got sum=%h c=%b ov=%b vld=%b want %h %b %b 1", ra, rb, sum,
                   carryout, overflow, out_valid, es, ec, ev);
      end
`ifdef SUB_ZERO_FLAG_EN
      checks++;
      if (zero !== (es == 32'h0)) begin
        failures++;
        if (bad++ < 5) $display("FAIL random_zero a=%h b=%h got %b want %b", ra, rb, zero, es == 32'h0);
      end
`endif
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_signed_min();
    test_borrow();
    test_equal_overflow();
    test_back_to_back();
    test_hold();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
